// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t   : sequencer FSM states
//   cnt_width : width of a counter able to reach the given cycle count
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // One spare bit above $clog2 so the terminal value always fits.
    function automatic int unsigned cnt_width(input int unsigned max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staged domain reset release.
// Holds the PLL in reset, waits for a stable lock (with timeout and retry
// budget), then releases the per-domain resets one after another.
//   refclk          : PLL reference clock, sole clock of this block
//   rst             : asynchronous active-high reset
//   pll_locked      : PLL lock indicator, asynchronous to refclk
//   restart_req     : single-cycle pulse forcing a full re-sequence
//   pll_rst         : reset to the PLL
//   domain_rst      : active-high reset per PLL output domain
//   ready           : all domains released and lock held
//   fault           : retry budget exhausted
//   lock_loss_count : lock losses after release, saturating at 255
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned NUM_DOMAINS         = 5
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [7:0]             lock_loss_count
);

    localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                      RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD  = (STAGE_GAP_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      STAGE_GAP_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = cnt_width(MAX_CYC);
    localparam int unsigned RW      = cnt_width(MAX_RETRIES);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    logic          lk;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= HOLD;
            cnt             <= '0;
            retry           <= '0;
            pll_rst         <= 1'b1;
            domain_rst      <= '1;
            ready           <= 1'b0;
            fault           <= 1'b0;
            lock_loss_count <= '0;
        end else if (restart_req) begin
            // Wins over a coincident lock loss, so no loss is counted.
            state      <= HOLD;
            cnt        <= '0;
            retry      <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else if (!lk && (state == RELEASE || state == RUN)) begin
            // Lock lost after release began: re-sequence, keep retry budget.
            state      <= HOLD;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry == RETRY_LIMIT) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= HOLD;
                            retry <= retry + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= RELEASE;
                        cnt           <= '0;
                        domain_rst[0] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Shifting in zeros from bit 0 releases the next domain
                    // without tracking an index.
                    if (domain_rst == '0) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        cnt        <= '0;
                        domain_rst <= domain_rst << 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                FAULT: begin
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer. Inputs for cycle k are applied
// on the falling edge before rising edge k; outputs for cycle k are sampled
// 1 ns after rising edge k. Edge 1 is the first rising edge after reset
// release (or the edge after a restart/loss event, relative to its base).
module tb_pll_reset_sequencer;

    localparam int P_HOLD   = 4;
    localparam int P_STABLE = 8;
    localparam int P_GAP    = 2;
    localparam int P_TO     = 32;
    localparam int P_RETRY  = 2;
    localparam int N        = 5;

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_locked = 1'b0;
    logic         restart_req = 1'b0;
    logic         pll_rst;
    logic [N-1:0] domain_rst;
    logic         ready;
    logic         fault;
    logic [7:0]   lock_loss_count;
    logic [N+2:0] obs;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    localparam logic [N+2:0] RESET_OBS = {1'b1, {N{1'b1}}, 2'b00};

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (P_HOLD),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .STAGE_GAP_CYCLES    (P_GAP),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_RETRY),
        .NUM_DOMAINS         (N)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .restart_req     (restart_req),
        .pll_rst         (pll_rst),
        .domain_rst      (domain_rst),
        .ready           (ready),
        .fault           (fault),
        .lock_loss_count (lock_loss_count)
    );

    assign obs = {pll_rst, domain_rst, ready, fault};

    always #5 refclk = ~refclk;

    // Reference timeline. b = edge at which a hold phase starts (0 after
    // reset), l = first input cycle from which pll_locked stays high.
    // The FSM sees the lock two edges after it is applied, and cannot
    // leave the hold earlier than b+P_HOLD+1.
    function automatic int stable_entry(int b, int l);
        return (b + P_HOLD + 1 > l + 2) ? b + P_HOLD + 1 : l + 2;
    endfunction

    function automatic int ready_at(int b, int l);
        return stable_entry(b, l) + P_STABLE + P_GAP * (N - 1) + 1;
    endfunction

    // Expected {pll_rst, domain_rst, ready, fault} after edge k.
    function automatic logic [N+2:0] model_at(int k, int b, int l);
        int           e;
        logic [N-1:0] dr;
        e = stable_entry(b, l) + P_STABLE;
        for (int i = 0; i < N; i++) dr[i] = (k < e + P_GAP * i);
        return {(k < b + P_HOLD), dr, (k >= e + P_GAP * (N - 1) + 1), 1'b0};
    endfunction

    task automatic drive_cycle(input logic lock, input logic req);
        @(negedge refclk);
        pll_locked  = lock;
        restart_req = req;
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pll_locked  = 1'b0;
        restart_req = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        pll_locked  = 1'b1;
        restart_req = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=%b", obs, RESET_OBS);
        end
        n_cmp++;
        if (lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_llc got=%0d want=0", lock_loss_count);
        end
    endtask

    task automatic test_lock_sequence();
        for (int it = 0; it < 4; it++) begin
            int l;
            int last;
            do_reset();
            l    = (it == 0) ? 10 : int'($urandom_range(1, 25));
            last = ready_at(0, l) + 3;
            for (int k = 1; k <= last; k++) begin
                drive_cycle(k >= l, 1'b0);
                n_cmp++;
                if (obs !== model_at(k, 0, l)) begin
                    n_fail++;
                    $display("FAIL lock_seq l=%0d k=%0d got=%b want=%b", l, k, obs, model_at(k, 0, l));
                end
            end
            n_cmp++;
            if (lock_loss_count !== 8'd0) begin
                n_fail++;
                $display("FAIL lock_seq_llc got=%0d want=0", lock_loss_count);
            end
        end
    endtask

    task automatic test_timeout();
        int           att;
        int           fault_at;
        int           extra;
        int           b;
        logic [N+2:0] want;
        att      = P_HOLD + P_TO;
        fault_at = (P_RETRY + 1) * att;
        extra    = int'($urandom_range(1, 10));
        do_reset();
        for (int k = 1; k <= fault_at + extra; k++) begin
            drive_cycle(1'b0, 1'b0);
            want = {(k >= fault_at) || ((k % att) < P_HOLD), {N{1'b1}}, 1'b0, (k >= fault_at)};
            n_cmp++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%b want=%b", k, obs, want);
            end
        end
        drive_cycle(1'b0, 1'b1);
        b = cyc;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL fault_restart got=%b want=%b", obs, RESET_OBS);
        end
        // Retry budget must be fresh: the next timeout returns to hold.
        for (int k = b + 1; k <= b + att + P_HOLD; k++) begin
            drive_cycle(1'b0, 1'b0);
            want = {((k - b) % att) < P_HOLD, {N{1'b1}}, 2'b00};
            n_cmp++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL retry_cleared k=%0d got=%b want=%b", k - b, obs, want);
            end
        end
    endtask

    task automatic test_restart_in_hold();
        int r;
        int l;
        int last;
        logic [N+2:0] want;
        do_reset();
        r    = int'($urandom_range(1, P_HOLD - 1));
        l    = int'($urandom_range(1, 20));
        last = ready_at(r, l) + 2;
        for (int k = 1; k <= last; k++) begin
            drive_cycle(k >= l, k == r);
            want = (k < r) ? model_at(k, 0, l) : model_at(k, r, l);
            n_cmp++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL restart_hold r=%0d k=%0d got=%b want=%b", r, k, obs, want);
            end
        end
    endtask

    task automatic test_glitch();
        int l;
        int g;
        int last;
        do_reset();
        l    = int'($urandom_range(1, 12));
        g    = stable_entry(0, l) - 2 + int'($urandom_range(1, P_STABLE));
        last = ready_at(0, g + 1) + 2;
        // A one-cycle drop seen in STABLE behaves like a fresh lock at g+1.
        for (int k = 1; k <= last; k++) begin
            drive_cycle((k >= l) && (k != g), 1'b0);
            n_cmp++;
            if (obs !== model_at(k, 0, g + 1)) begin
                n_fail++;
                $display("FAIL glitch g=%0d k=%0d got=%b want=%b", g, k, obs, model_at(k, 0, g + 1));
            end
        end
        n_cmp++;
        if (lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_llc got=%0d want=0", lock_loss_count);
        end
    endtask

    // Drop lock for three input cycles in RUN; with_restart also pulses
    // restart_req on the edge where the drop is first seen.
    task automatic run_drop(input logic with_restart, input logic [7:0] exp_llc);
        int l;
        int d;
        int last;
        logic [N+2:0] want;
        do_reset();
        l    = int'($urandom_range(1, 20));
        d    = ready_at(0, l) + int'($urandom_range(1, 10));
        last = ready_at(d + 2, d + 3) + 2;
        for (int k = 1; k <= last; k++) begin
            drive_cycle((k >= l) && !(k >= d && k <= d + 2), with_restart && (k == d + 2));
            want = (k < d + 2) ? model_at(k, 0, l) : model_at(k, d + 2, d + 3);
            n_cmp++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL drop rq=%0b k=%0d got=%b want=%b", with_restart, k, obs, want);
            end
            if (k == d + 2) begin
                n_cmp++;
                if (lock_loss_count !== exp_llc) begin
                    n_fail++;
                    $display("FAIL drop_llc rq=%0b got=%0d want=%0d", with_restart, lock_loss_count, exp_llc);
                end
            end
        end
        n_cmp++;
        if (lock_loss_count !== exp_llc) begin
            n_fail++;
            $display("FAIL drop_llc_end rq=%0b got=%0d want=%0d", with_restart, lock_loss_count, exp_llc);
        end
    endtask

    task automatic test_lock_loss();
        run_drop(1'b0, 8'd1);
    endtask

    task automatic test_restart_with_drop();
        run_drop(1'b1, 8'd0);
    endtask

    task automatic test_saturation();
        int budget;
        int exp_n;
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            budget = 0;
            while (domain_rst[0] !== 1'b0 && budget < 60) begin
                drive_cycle(1'b1, 1'b0);
                budget++;
            end
            if (domain_rst[0] !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sat_wait n=%0d got=%b want=release", n, domain_rst);
                break;
            end
            repeat (3) drive_cycle(1'b0, 1'b0);
            exp_n = (n < 255) ? n : 255;
            n_cmp++;
            if (lock_loss_count !== 8'(exp_n)) begin
                n_fail++;
                $display("FAIL sat_llc n=%0d got=%0d want=%0d", n, lock_loss_count, exp_n);
            end
        end
    endtask

    task automatic test_async_reset_mid_release();
        int           budget;
        int           l;
        int           last;
        logic [N-1:0] mid;
        mid    = {{(N - 2){1'b1}}, 2'b00};
        budget = 0;
        while (domain_rst !== mid && budget < 60) begin
            drive_cycle(1'b1, 1'b0);
            budget++;
        end
        n_cmp++;
        if (domain_rst !== mid) begin
            n_fail++;
            $display("FAIL mid_release_wait got=%b want=%b", domain_rst, mid);
        end
        // Well clear of either clock edge: only the async path can act.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL async_reset got=%b want=%b", obs, RESET_OBS);
        end
        n_cmp++;
        if (lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_llc got=%0d want=0", lock_loss_count);
        end
        @(posedge refclk);
        #1;
        rst = 1'b0;
        cyc = 0;
        l    = int'($urandom_range(1, 20));
        last = ready_at(0, l) + 2;
        for (int k = 1; k <= last; k++) begin
            drive_cycle(k >= l, 1'b0);
            n_cmp++;
            if (obs !== model_at(k, 0, l)) begin
                n_fail++;
                $display("FAIL post_reset k=%0d got=%b want=%b", k, obs, model_at(k, 0, l));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout();
        test_restart_in_hold();
        test_glitch();
        test_lock_loss();
        test_restart_with_drop();
        test_saturation();
        test_async_reset_mid_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles pll_rst is held high per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release.
REQ-003 SHALL have parameter STAGE_GAP_CYCLES, default 8: cycles between successive domain reset releases.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum wait for lock per attempt.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: timed-out attempts allowed before FAULT.
REQ-006 SHALL have parameter NUM_DOMAINS, default 5: one domain per PLL output clock.
REQ-007 SHALL have port refclk, input, 1: sole clock, the PLL reference clock.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-010 SHALL have port restart_req, input, 1: single-cycle pulse requesting a full re-sequence.
REQ-011 SHALL have port pll_rst, output, 1: reset driven to the PLL.
REQ-012 SHALL have port domain_rst, output, NUM_DOMAINS: active-high per-domain resets.
REQ-013 SHALL have port ready, output, 1: all domains released and lock held.
REQ-014 SHALL have port fault, output, 1: retry budget exhausted.
REQ-015 SHALL have port lock_loss_count, output, 8: count of lock losses, saturating at 255.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer; all decisions SHALL use the synced value (lk).
REQ-017 SHALL implement states HOLD, WAIT_LOCK, STABLE, RELEASE, RUN and FAULT.
REQ-018 HOLD: pll_rst=1 for exactly RST_HOLD_CYCLES cycles, then -> WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_rst=0; lk=1 -> STABLE; timeout counter reaching LOCK_TIMEOUT_CYCLES -> retry++ and -> HOLD, or -> FAULT once retry==MAX_RETRIES.
REQ-020 STABLE: lk=1 for LOCK_STABLE_CYCLES consecutive cycles -> RELEASE; any lk=0 -> WAIT_LOCK with the stable counter cleared and no lock_loss_count change.
REQ-021 RELEASE: domain_rst[0] SHALL deassert on the first RELEASE cycle and domain_rst[i] exactly STAGE_GAP_CYCLES cycles after domain_rst[i-1]; after domain_rst[NUM_DOMAINS-1] deasserts -> RUN.
REQ-022 RUN: ready=1; ready SHALL be 0 in every other state.
REQ-023 lk=0 in RELEASE or RUN SHALL, on the next edge, assert all domain_rst bits, clear ready, increment lock_loss_count (saturating) and enter HOLD; retry count SHALL be unchanged.
REQ-024 Once asserted, domain_rst bits SHALL stay asserted in HOLD, WAIT_LOCK, STABLE and FAULT.
REQ-025 FAULT: pll_rst=1, fault=1; exit only via restart_req (-> HOLD) or rst.
REQ-026 restart_req in any state SHALL clear retry and all counters, assert all domain_rst and enter HOLD; restart_req in HOLD SHALL restart the hold count.
REQ-027 restart_req coincident with lk=0 SHALL take priority, and lock_loss_count SHALL NOT increment.
REQ-028 Counter widths SHALL be $clog2 of the largest cycle parameter plus 1; every output SHALL be registered.

Reset
REQ-029 While rst=1 the block SHALL hold pll_rst=1, domain_rst all ones, ready=0, fault=0, lock_loss_count=0, retry=0, synchronizer flops=0 and state=HOLD.
REQ-030 After rst deasserts, the HOLD count SHALL start from zero on the first refclk edge.

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state enum and the counter-width helper function.
REQ-032 The synchronizer SHALL be the sub-module sync_2ff; everything else SHALL be a single FSM in one module.

Verification (RST_HOLD=4, LOCK_STABLE=8, STAGE_GAP=2, LOCK_TIMEOUT=32, MAX_RETRIES=2, NUM_DOMAINS=5)
REQ-033 Bench: rst release, then pll_locked=1 at cycle 10 -> pll_rst low at cycles 4-10; STABLE reached 2 cycles after lock; domain_rst[0..4] release 2 cycles apart; ready=1 one cycle after domain_rst=0.
REQ-034 Bench: pll_locked never rises -> three HOLD/WAIT_LOCK attempts of 4+32 cycles each, then fault=1 with pll_rst=1 held; restart_req -> fault=0 and HOLD.
REQ-035 Bench: in RUN, drop pll_locked for 3 cycles -> domain_rst=5'h1F and ready=0 within 3 cycles of the drop; lock_loss_count=1; full re-sequence follows.
REQ-036 Bench: glitch pll_locked low for 1 synced cycle during STABLE -> return to WAIT_LOCK; stable count restarts; lock_loss_count stays 0.
REQ-037 Bench: restart_req and lock drop in the same RUN cycle -> HOLD; lock_loss_count unchanged; then force 300 lock losses -> lock_loss_count=255.
REQ-038 Bench: assert rst mid-RELEASE with domain_rst=5'h1C -> outputs immediately at reset values, asynchronously to refclk.
